// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH encode/decode chain.
// Defaults describe the (15,7) code with g(x) = x^8 + x^7 + x^6 + x^4 + 1.
package bch_pkg;

  localparam int BCH_N = 15;
  localparam int BCH_K = 7;

  // Number of parity bits for the default code.
  localparam int PAR = BCH_N - BCH_K;

  // Generator polynomial, bit i is the coefficient of x^i.
  localparam logic [PAR:0] BCH_GEN_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bch_state_e;

endpackage

// File: rtl/bch_parity_lfsr.sv
// Parity register for systematic BCH encoding: one step of polynomial
// division of m(x)*x^PAR by g(x) per enabled clock, message MSB first.
// clr has priority over en; the caller sequences the message bits.
module bch_parity_lfsr #(
  parameter int           PAR  = 8,
  parameter logic [PAR:0] POLY = 9'h1D1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           data_bit,
  output logic [PAR-1:0] parity
);

  logic [PAR-1:0] lfsr_q;
  logic [PAR-1:0] lfsr_d;
  logic           fb;

  // Next remainder: shift left, fold g(x) back in when the feedback bit is set.
  always_comb begin
    lfsr_d = lfsr_q;
    fb     = data_bit ^ lfsr_q[PAR-1];
    if (clr) begin
      lfsr_d = '0;
    end else if (en) begin
      lfsr_d = {lfsr_q[PAR-2:0], 1'b0} ^ (fb ? POLY[PAR-1:0] : '0);
    end
  end

  // Remainder register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign parity = lfsr_q;

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH encoder: codeword_out = {message, parity}.
// Optional build macro BCH_ERROR_INJECT_EN adds an err_mask input that is
// XORed onto the registered codeword (parity still uses the clean message).
//
// Handshake: start_encode is a level request. It is sampled in IDLE together
// with message (and err_mask); the requester keeps it high until it sees
// finished_encode, then drops it. finished_encode stays high while start is
// held in DONE and falls on the edge after start drops. Dropping start before
// finished_encode aborts the encode with codeword_out left untouched.
module bch_encoder
  import bch_pkg::*;
#(
  parameter int             N        = BCH_N,
  parameter int             K        = BCH_K,
  parameter logic [N-K:0]   GEN_POLY = BCH_GEN_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_encode,
  input  logic [K-1:0] message,
`ifdef BCH_ERROR_INJECT_EN
  input  logic [N-1:0] err_mask,
`endif
  output logic [N-1:0] codeword_out,
  output logic         busy,
  output logic         finished_encode
);

  localparam int PW = N - K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  bch_state_e     state_q, state_d;
  logic [K-1:0]   msg_q, msg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Set after the last message bit has been shifted; gives the one spare
  // SHIFT cycle before DONE so finished rises K+2 edges after the start edge.
  logic           tail_q, tail_d;
  logic [N-1:0]   cw_q, cw_d;
  logic           fin_q, fin_d;
  logic           lfsr_clr;
  logic           lfsr_en;
  logic [PW-1:0]  parity;
  logic [N-1:0]   cw_mask;

`ifdef BCH_ERROR_INJECT_EN
  logic [N-1:0]   err_q, err_d;
  assign cw_mask = err_q;
`else
  assign cw_mask = '0;
`endif

  bch_parity_lfsr #(
    .PAR  (PW),
    .POLY (GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .clr      (lfsr_clr),
    .en       (lfsr_en),
    .data_bit (msg_q[cnt_q]),
    .parity   (parity)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    cnt_d    = cnt_q;
    tail_d   = tail_q;
    cw_d     = cw_q;
    fin_d    = fin_q;
    lfsr_clr = 1'b0;
    lfsr_en  = 1'b0;
`ifdef BCH_ERROR_INJECT_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        fin_d = 1'b0;
        if (start_encode) begin
          msg_d    = message;
`ifdef BCH_ERROR_INJECT_EN
          err_d    = err_mask;
`endif
          lfsr_clr = 1'b1;
          cnt_d    = CW'(K - 1);
          tail_d   = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!start_encode) begin
          state_d = ST_IDLE;
        end else if (tail_q) begin
          state_d = ST_DONE;
        end else begin
          lfsr_en = 1'b1;
          if (cnt_q == '0) tail_d = 1'b1;
          else             cnt_d  = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (!start_encode) begin
          fin_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (!fin_q) begin
          cw_d  = {msg_q, parity} ^ cw_mask;
          fin_d = 1'b1;
        end
      end
      default: begin
        fin_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      cw_q    <= '0;
      fin_q   <= 1'b0;
`ifdef BCH_ERROR_INJECT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      cw_q    <= cw_d;
      fin_q   <= fin_d;
`ifdef BCH_ERROR_INJECT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign codeword_out    = cw_q;
  assign finished_encode = fin_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
